// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared defaults, block index type and controller state enum
//                for the parking slot arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int NBLK_DEF = 8;
    localparam int CAP_DEF  = 3;
    localparam int TMO_DEF  = 16;
    localparam int BLK_W    = $clog2(NBLK_DEF);

    typedef logic [BLK_W-1:0] blk_idx_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin finder: first set request bit at
//                or above ptr_i, wrapping around to bit 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NBLK  = 8,
    parameter int IDX_W = $clog2(NBLK)
) (
    input  logic [NBLK-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        logic [IDX_W:0] pos;
        pos     = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = NBLK - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NBLK)) begin
                pos = pos - (IDX_W + 1)'(NBLK);
            end
            if (req_i[pos[IDX_W-1:0]]) begin
                idx_o   = pos[IDX_W-1:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/parking_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : parking_slot_arbiter
//  Description : Turns block-button presses into a registered round-robin
//                grant, reserves a slot, tracks per-block occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_slot_arbiter
    import parking_pkg::*;
#(
    parameter int NBLK   = NBLK_DEF,
    parameter int CAP    = CAP_DEF,
    parameter int TMO    = TMO_DEF,
    parameter int IDX_W  = $clog2(NBLK),
    parameter int FREE_W = $clog2(NBLK * CAP + 1)
) (
    input  logic              CKT,
    input  logic              RST,
    input  logic [NBLK-1:0]   B,
    input  logic              PARKED,
    input  logic              EXIT,
    input  logic [IDX_W-1:0]  EXIT_BLK,
    output logic [IDX_W-1:0]  F,
    output logic              BUSY,
    output logic [NBLK-1:0]   FULL,
    output logic [FREE_W-1:0] FREE,
    output logic              TOUT
);

    localparam int CNT_W = $clog2(CAP + 1);
    localparam int TMO_W = $clog2(TMO + 1);

    state_t             st_q, st_d;
    logic [IDX_W-1:0]   f_q, f_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               tout_q, tout_d;
    logic [NBLK-1:0]    b_q;
    logic [CNT_W-1:0]   cnt_q [NBLK];
    logic [CNT_W-1:0]   cnt_d [NBLK];

    logic [NBLK-1:0]    req;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               grant;
    logic               rel;

    assign req = B & ~b_q & ~FULL;

    rr_pick #(
        .NBLK  (NBLK),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        st_d   = st_q;
        f_d    = f_q;
        ptr_d  = ptr_q;
        tmo_d  = tmo_q;
        tout_d = 1'b0;
        grant  = 1'b0;
        rel    = 1'b0;
        case (st_q)
            IDLE: begin
                if (pick_valid) begin
                    grant = 1'b1;
                    f_d   = pick_idx;
                    ptr_d = (pick_idx == IDX_W'(NBLK - 1)) ? '0 : pick_idx + 1'b1;
                    tmo_d = '0;
                    st_d  = WAIT;
                end
            end
            WAIT: begin
                // A park arriving on the timeout cycle keeps the reservation.
                if (PARKED) begin
                    st_d = IDLE;
                end else if (tmo_q == TMO_W'(TMO - 1)) begin
                    rel    = 1'b1;
                    tout_d = 1'b1;
                    st_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // Grant, exit and release may all hit one block; the net is clamped.
    always_comb begin
        int tot;
        tot = 0;
        for (int i = 0; i < NBLK; i++) begin
            tot = int'(cnt_q[i]);
            if (grant && pick_idx == IDX_W'(i)) begin
                tot = tot + 1;
            end
            if (EXIT && EXIT_BLK == IDX_W'(i) && cnt_q[i] != '0) begin
                tot = tot - 1;
            end
            if (rel && f_q == IDX_W'(i)) begin
                tot = tot - 1;
            end
            if (tot < 0) begin
                tot = 0;
            end
            if (tot > CAP) begin
                tot = CAP;
            end
            cnt_d[i] = CNT_W'(tot);
        end
    end

    always_ff @(posedge CKT) begin
        // Tracking B through reset keeps a held button from looking like a press.
        b_q <= B;
        if (RST) begin
            st_q   <= IDLE;
            f_q    <= '0;
            ptr_q  <= '0;
            tmo_q  <= '0;
            tout_q <= 1'b0;
            for (int i = 0; i < NBLK; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            st_q   <= st_d;
            f_q    <= f_d;
            ptr_q  <= ptr_d;
            tmo_q  <= tmo_d;
            tout_q <= tout_d;
            for (int i = 0; i < NBLK; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NBLK; g++) begin : g_full
            assign FULL[g] = (cnt_q[g] == CNT_W'(CAP));
        end
    endgenerate

    always_comb begin
        int used;
        used = 0;
        for (int i = 0; i < NBLK; i++) begin
            used = used + int'(cnt_q[i]);
        end
        FREE = FREE_W'(NBLK * CAP - used);
    end

    assign F    = f_q;
    assign BUSY = (st_q == WAIT);
    assign TOUT = tout_q;

endmodule
`default_nettype wire
